// File: rtl/memcpy_sched_pkg.sv
// Shared types and constants for the memcpy job sequencer.
// Status-line layout offsets are consumed by the c1 status writer.
package memcpy_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } t_sched_state;

  localparam int DEFAULT_MAX_INFLIGHT = 62;
  localparam int DEFAULT_ADDR_W       = 42;

  localparam int STATUS_DONE_BIT   = 0;
  localparam int STATUS_CLK_LO     = 64;
  localparam int STATUS_CLK_HI     = 127;
  localparam int STATUS_ISSUED_LO  = 128;
  localparam int STATUS_ISSUED_HI  = 159;
  localparam int STATUS_WR_DONE_LO = 160;
  localparam int STATUS_WR_DONE_HI = 191;

  function automatic logic [31:0] rsp_ext(
    input logic [2:0] lines
  );
    return {29'd0, lines};
  endfunction

endpackage

// File: rtl/sched_credit_ctr.sv
// Issued / write-done line counters, in-flight credit
// compare and sticky overflow detect.
module sched_credit_ctr
  import memcpy_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        run,
  input  logic        issue,
  input  logic        rsp_valid,
  input  logic [2:0]  rsp_lines,
  input  logic [31:0] num_lines,
  output logic [31:0] issued,
  output logic [31:0] wr_done,
  output logic        credit_ok,
  output logic        ovf_err
);

  logic [31:0] inflight;
  logic        over;

  // wr_done > issued wraps to a huge value and blocks issue
  assign inflight  = issued - wr_done;
  assign credit_ok = inflight < 32'(MAX_INFLIGHT);
  assign over      = (wr_done > num_lines) ||
                     (wr_done > issued);

  always_ff @(posedge clk) begin
    if (reset) begin
      issued  <= '0;
      wr_done <= '0;
      ovf_err <= 1'b0;
    end else if (clear) begin
      issued  <= '0;
      wr_done <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (run && issue)
        issued <= issued + 32'd1;
      if (run && rsp_valid)
        wr_done <= wr_done + rsp_ext(rsp_lines);
      if (over)
        ovf_err <= 1'b1;
    end
  end

endmodule

// File: rtl/memcpy_job_sched.sv
// Job sequencer: accepts a CSR job, issues c0 read headers
// under credit/almost-full throttling, then requests status.
module memcpy_job_sched
  import memcpy_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT,
  parameter int ADDR_W       = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [31:0]       num_lines,
  input  logic              c0_alm_full,
  input  logic              c1_alm_full,
  input  logic              wfifo_alm_full,
  input  logic              wr_rsp_valid,
  input  logic [2:0]        wr_rsp_lines,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [15:0]       rd_req_mdata,
  output logic              status_req_valid,
  input  logic              status_req_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              ovf_err,
  output logic [63:0]       clk_cnt,
  output logic [31:0]       issued_cnt,
  output logic [31:0]       wr_done_cnt,
  output logic [1:0]        state
);

  t_sched_state      st_q;
  t_sched_state      st_d;
  logic [ADDR_W-1:0] src_q;
  logic [31:0]       num_q;
  logic              in_run;
  logic              in_report;
  logic              accept;
  logic              job_end;
  logic              no_alm;
  logic              credit_ok;
  logic              can_issue;

  assign in_run    = st_q == ST_RUN;
  assign in_report = st_q == ST_REPORT;
  assign accept    = (st_q == ST_IDLE) && start &&
                     (num_lines != 32'd0);
  assign job_end   = (issued_cnt == num_q) &&
                     (wr_done_cnt >= num_q);
  assign no_alm    = !c0_alm_full && !c1_alm_full &&
                     !wfifo_alm_full;
  assign can_issue = in_run && no_alm && credit_ok &&
                     (issued_cnt < num_q);
  assign state     = st_q;

  sched_credit_ctr #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .run      (in_run),
    .issue    (can_issue),
    .rsp_valid(wr_rsp_valid),
    .rsp_lines(wr_rsp_lines),
    .num_lines(num_q),
    .issued   (issued_cnt),
    .wr_done  (wr_done_cnt),
    .credit_ok(credit_ok),
    .ovf_err  (ovf_err)
  );

  always_comb begin
    st_d             = st_q;
    busy             = 1'b1;
    status_req_valid = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept)
          st_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort || job_end)
          st_d = ST_REPORT;
      end
      ST_REPORT: begin
        status_req_valid = 1'b1;
        if (status_req_ack)
          st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= ST_IDLE;
      src_q        <= '0;
      num_q        <= '0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      clk_cnt      <= '0;
    end else begin
      st_q         <= st_d;
      done         <= in_report && status_req_ack;
      rd_req_valid <= can_issue;
      if (can_issue) begin
        rd_req_addr  <= src_q + ADDR_W'(issued_cnt);
        rd_req_mdata <= issued_cnt[15:0];
      end
      if (accept) begin
        src_q   <= src_addr;
        num_q   <= num_lines;
        aborted <= 1'b0;
        clk_cnt <= '0;
      end else if (in_run) begin
        clk_cnt <= clk_cnt + 64'd1;
        if (abort)
          aborted <= 1'b1;
      end
    end
  end

endmodule
